// File: rtl/mem_access_unit.sv
//-----------------------------------------------------------------------------
// mem_access_unit
//
// MEM stage of the 5-stage RISC-V core. It consumes the EX/MEM pipeline
// register and does three things:
//   * runs load/store operations on the data-memory req/ack bus, including
//     byte lanes, alignment checks and sign/zero extension of loads;
//   * asks the pipeline controller to stall while an access is in flight;
//   * forwards the write-back triple (wd, wreg, wdata) to MEM/WB.
//
// Parameters
//   TIMEOUT       maximum BUSY cycles spent waiting for dm_ack (0 = no limit)
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   stall[5:0]    pipeline stall vector; bit 4 holds the MEM stage
//   mem_aluop     operation code from EX/MEM
//   mem_mem_addr  byte address
//   mem_reg2      store data
//   mem_wd        destination register
//   mem_wreg      write-register flag
//   mem_wdata     ALU result, used by non-memory ops
//   dm_req        bus request (registered)
//   dm_we         1 = store (registered)
//   dm_addr       word-aligned bus address (registered)
//   dm_be         byte enables (registered)
//   dm_wdata      lane-replicated store data (registered)
//   dm_rdata      read data, valid only together with dm_ack
//   dm_ack        single-cycle completion strobe
//   stallreq_mem  stall request to the pipeline controller
//   wb_wd         destination register to MEM/WB
//   wb_wreg       write-enable to MEM/WB
//   wb_wdata      write-back data to MEM/WB
//   misalign      misaligned-access flag (combinational)
//   bus_err       one-cycle pulse when an access times out
//-----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stallreq_mem,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        misalign,
  output logic        bus_err
);

  // Memory opcodes; every other aluop value is a non-memory operation.
  localparam logic [4:0] OP_LB  = 5'b10000;
  localparam logic [4:0] OP_LH  = 5'b10001;
  localparam logic [4:0] OP_LW  = 5'b10010;
  localparam logic [4:0] OP_LBU = 5'b10011;
  localparam logic [4:0] OP_LHU = 5'b10100;
  localparam logic [4:0] OP_SB  = 5'b10101;
  localparam logic [4:0] OP_SH  = 5'b10110;
  localparam logic [4:0] OP_SW  = 5'b10111;

  // The timer only ever counts up to TIMEOUT-1.
  localparam int              TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef struct packed {
    logic  is_mem;
    logic  is_load;
    logic  is_unsigned;
    size_e size;
  } mem_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e        state_q;
  state_e        state_d;
  mem_op_t       op;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata;
  logic          start;
  logic          timeout_hit;

  // Attributes of the access in flight, captured when it starts.
  logic          ld_q;
  logic          unsigned_q;
  size_e         size_q;
  logic [1:0]    off_q;
  logic [TW-1:0] timer_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  // Only the MEM-stage hold bit matters here.
  logic          unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  //---------------------------------------------------------------------------
  // Opcode decode
  //---------------------------------------------------------------------------
  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    op = '{is_mem: 1'b0, is_load: 1'b0, is_unsigned: 1'b0, size: SZ_WORD};
    unique case (mem_aluop)
      OP_LB:   op = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b0, size: SZ_BYTE};
      OP_LH:   op = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b0, size: SZ_HALF};
      OP_LW:   op = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b0, size: SZ_WORD};
      OP_LBU:  op = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b1, size: SZ_BYTE};
      OP_LHU:  op = '{is_mem: 1'b1, is_load: 1'b1, is_unsigned: 1'b1, size: SZ_HALF};
      OP_SB:   op = '{is_mem: 1'b1, is_load: 1'b0, is_unsigned: 1'b0, size: SZ_BYTE};
      OP_SH:   op = '{is_mem: 1'b1, is_load: 1'b0, is_unsigned: 1'b0, size: SZ_HALF};
      OP_SW:   op = '{is_mem: 1'b1, is_load: 1'b0, is_unsigned: 1'b0, size: SZ_WORD};
      default: ;
    endcase
  end

  // Halfwords must sit on even addresses, words on multiples of four.
  always_comb begin
    misalign = 1'b0;
    if (op.is_mem) begin
      unique case (op.size)
        SZ_HALF: misalign = mem_mem_addr[0];
        SZ_WORD: misalign = (mem_mem_addr[1:0] != 2'b00);
        default: misalign = 1'b0;
      endcase
    end
  end

  //---------------------------------------------------------------------------
  // Byte lanes and store-data replication for the access about to start
  //---------------------------------------------------------------------------
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = 32'h0;
    if (op.is_mem && !op.is_load) begin
      unique case (op.size)
        SZ_BYTE: begin
          req_be    = 4'b0001 << mem_mem_addr[1:0];
          req_wdata = {4{mem_reg2[7:0]}};
        end
        SZ_HALF: begin
          req_be    = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
          req_wdata = {2{mem_reg2[15:0]}};
        end
        default: begin
          req_be    = 4'b1111;
          req_wdata = mem_reg2;
        end
      endcase
    end
  end

  //---------------------------------------------------------------------------
  // Load lane selection and extension, applied to dm_rdata as it arrives
  //---------------------------------------------------------------------------
  always_comb begin
    byte_sel = dm_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    load_ext = dm_rdata;
    unique case (size_q)
      SZ_BYTE: load_ext = unsigned_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_ext = unsigned_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = dm_rdata;
    endcase
  end

  assign start       = (state_q == S_IDLE) && op.is_mem && !misalign;
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

  //---------------------------------------------------------------------------
  // FSM: state register
  //---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking assignments only, so every register
  // samples the pre-edge values regardless of block or statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  //---------------------------------------------------------------------------
  // FSM: next-state logic
  //---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_BUSY;
      S_BUSY: if (dm_ack || timeout_hit) state_d = S_DONE;
      S_DONE: if (!stall[4]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  //---------------------------------------------------------------------------
  // FSM: outputs to the controller and MEM/WB
  //---------------------------------------------------------------------------
  always_comb begin
    stallreq_mem = 1'b0;
    wb_wd        = mem_wd;
    wb_wreg      = 1'b0;
    wb_wdata     = 32'h0;
    unique case (state_q)
      S_IDLE: begin
        if (!op.is_mem) begin
          wb_wreg  = mem_wreg;
          wb_wdata = mem_wdata;
        end else if (!misalign) begin
          stallreq_mem = 1'b1;
        end
      end
      S_BUSY: stallreq_mem = 1'b1;
      S_DONE: begin
        // A timed-out load must not write its (stale) data back.
        if (ld_q) begin
          wb_wreg  = mem_wreg & ~err_q;
          wb_wdata = rdata_q;
        end
      end
      default: ;
    endcase
  end

  //---------------------------------------------------------------------------
  // Bus-side registers, access attributes, timer and error flag
  //---------------------------------------------------------------------------
  // NOTE: these registers drive the bus and the write-back path directly, so
  // all of them are reset; an un-reset dm_req could issue a spurious cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= 32'h0;
      dm_be      <= 4'h0;
      dm_wdata   <= 32'h0;
      ld_q       <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= SZ_WORD;
      off_q      <= 2'b00;
      timer_q    <= '0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= 1'b0;

      if (start) begin
        dm_req     <= 1'b1;
        dm_we      <= ~op.is_load;
        dm_addr    <= {mem_mem_addr[31:2], 2'b00};
        dm_be      <= req_be;
        dm_wdata   <= req_wdata;
        ld_q       <= op.is_load;
        unsigned_q <= op.is_unsigned;
        size_q     <= op.size;
        off_q      <= mem_mem_addr[1:0];
        timer_q    <= '0;
      end

      // An ack arriving on the last allowed cycle still completes normally.
      if (state_q == S_BUSY) begin
        if (dm_ack) begin
          dm_req  <= 1'b0;
          rdata_q <= load_ext;
        end else if (timeout_hit) begin
          dm_req  <= 1'b0;
          bus_err <= 1'b1;
          err_q   <= 1'b1;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
      end

      if ((state_q == S_DONE) && !stall[4]) begin
        err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
//-----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. Expected bus lanes, load values,
// stall lengths and write-back fields come from a small reference model that
// works from the opcode table with plain arithmetic (sizes, shifts, masks).
// The DUT is built with a short timeout so the timeout path is reachable.
//-----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int TO = 4;

  localparam logic [4:0] LB  = 5'b10000;
  localparam logic [4:0] LH  = 5'b10001;
  localparam logic [4:0] LW  = 5'b10010;
  localparam logic [4:0] LBU = 5'b10011;
  localparam logic [4:0] LHU = 5'b10100;
  localparam logic [4:0] SB  = 5'b10101;
  localparam logic [4:0] SH  = 5'b10110;
  localparam logic [4:0] SW  = 5'b10111;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        stallreq_mem;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        misalign;
  logic        bus_err;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_be        (dm_be),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata),
    .dm_ack       (dm_ack),
    .stallreq_mem (stallreq_mem),
    .wb_wd        (wb_wd),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata),
    .misalign     (misalign),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  //---------------------------------------------------------------------------
  // Reference model
  //---------------------------------------------------------------------------
  function automatic int op_size(input logic [4:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic bit is_load(input logic [4:0] op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic bit is_misaligned(input logic [4:0] op, input logic [31:0] addr);
    int s;
    s = op_size(op);
    return (s != 0) && ((int'(addr[1:0]) % s) != 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [4:0] op, input logic [31:0] addr);
    int s;
    s = op_size(op);
    if (is_load(op)) return 4'hF;
    return 4'(((1 << s) - 1) << addr[1:0]);
  endfunction

  function automatic logic [31:0] exp_store(input logic [4:0] op, input logic [31:0] reg2);
    logic [31:0] v;
    case (op_size(op))
      1:       v = reg2[7:0] * 32'h0101_0101;
      2:       v = reg2[15:0] * 32'h0001_0001;
      default: v = reg2;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] exp_load(input logic [4:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * addr[1:0]);
    case (op_size(op))
      1: begin
        v = v & 32'hFF;
        if (op == LB && v >= 32'd128) v = v - 32'd256;
      end
      2: begin
        v = v & 32'hFFFF;
        if (op == LH && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  //---------------------------------------------------------------------------
  // One operation through the MEM stage. Called just after a rising edge.
  // delay: BUSY cycles before ack (0 = ack on the first BUSY cycle); -1 = never.
  // hold:  cycles to keep stall[4] asserted once DONE is reached.
  //---------------------------------------------------------------------------
  task automatic run_op(input logic [4:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [31:0] rdata,
                        input logic [31:0] alu, input logic [4:0] wd,
                        input logic wreg, input int delay, input int hold);
    int  stall_cnt;
    int  req_cnt;
    bit  done;
    bit  tmo;
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    mem_wd       = wd;
    mem_wreg     = wreg;
    mem_wdata    = alu;
    stall        = 6'($urandom) & 6'h2F;
    dm_ack       = 1'b0;
    tmo          = (delay < 0);

    if (op_size(op) == 0) begin
      @(negedge clk);
      check("alu_wd", wb_wd, wd);
      check("alu_wreg", wb_wreg, wreg);
      check("alu_wdata", wb_wdata, alu);
      check("alu_stall", stallreq_mem, 0);
      check("alu_req", dm_req, 0);
      @(posedge clk); #1;
      return;
    end

    if (is_misaligned(op, addr)) begin
      @(negedge clk);
      check("mis_flag", misalign, 1);
      check("mis_stall", stallreq_mem, 0);
      check("mis_wreg", wb_wreg, 0);
      check("mis_req", dm_req, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("mis_noreq", dm_req, 0);
      @(posedge clk); #1;
      return;
    end

    stall_cnt = 0;
    req_cnt   = 0;
    done      = 1'b0;
    for (int cyc = 0; cyc < 24 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check("aligned_flag", misalign, 0);
      if (stallreq_mem) begin
        stall_cnt++;
        check("busy_wreg_err", {wb_wreg, bus_err}, 0);
        check("busy_wdata", wb_wdata, 0);
        if (dm_req) begin
          req_cnt++;
          check("bus_addr", dm_addr, addr & ~32'h3);
          check("bus_we", dm_we, !is_load(op));
          check("bus_be", dm_be, exp_be(op, addr));
          if (!is_load(op)) check("bus_wdata", dm_wdata, exp_store(op, reg2));
          if (!tmo && req_cnt == delay + 1) begin
            dm_ack   = 1'b1;
            dm_rdata = rdata;
          end else begin
            dm_ack   = 1'b0;
            dm_rdata = $urandom;
          end
        end
      end else begin
        done = 1'b1;
        check("stall_cycles", stall_cnt, tmo ? TO + 1 : delay + 2);
        check("req_cycles", req_cnt, tmo ? TO : delay + 1);
        check("done_req", dm_req, 0);
        check("done_bus_err", bus_err, tmo);
        check("done_wd", wb_wd, wd);
        check("done_wreg", wb_wreg, is_load(op) && wreg && !tmo);
        if (is_load(op) && !tmo) check("load_data", wb_wdata, exp_load(op, addr, rdata));
        if (tmo) begin
          dm_ack   = 1'b1;
          dm_rdata = $urandom;
        end
        if (hold > 0) stall[4] = 1'b1;
        for (int h = 1; h <= hold; h++) begin
          @(posedge clk); #1;
          @(negedge clk);
          check("hold_stall", stallreq_mem, 0);
          check("hold_req_err", {dm_req, bus_err}, 0);
          check("hold_wreg", wb_wreg, is_load(op) && wreg && !tmo);
          if (is_load(op) && !tmo) check("hold_data", wb_wdata, exp_load(op, addr, rdata));
          if (h == hold) stall[4] = 1'b0;
        end
      end
      @(posedge clk); #1;
      dm_ack = 1'b0;
    end
    if (!done) check("done_wait", 0, 1);
  endtask

  //---------------------------------------------------------------------------
  // Stimulus
  //---------------------------------------------------------------------------
  initial begin
    logic [4:0]  op;
    logic [31:0] addr;
    int          r;
    int          dly;

    rst          = 1'b0;
    stall        = 6'h0;
    mem_aluop    = 5'b00000;
    mem_mem_addr = 32'h0;
    mem_reg2     = 32'h0;
    mem_wd       = 5'd0;
    mem_wreg     = 1'b0;
    mem_wdata    = 32'h0;
    dm_rdata     = 32'h0;
    dm_ack       = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req", dm_req, 0);
    check("rst_we_be", {dm_we, dm_be}, 0);
    check("rst_addr", dm_addr, 0);
    check("rst_wdata", dm_wdata, 0);
    check("rst_err_stall", {bus_err, stallreq_mem}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(5'b00001, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd5, 1'b1, 0, 0);
    run_op(LB,  32'h0000_0103, 32'h0, 32'h80AA_55CC, 32'h0, 5'd7, 1'b1, 3, 0);
    run_op(LBU, 32'h0000_0103, 32'h0, 32'h80AA_55CC, 32'h0, 5'd7, 1'b1, 3, 0);
    run_op(SH,  32'h0000_0202, 32'h1234_ABCD, 32'h0, 32'h0, 5'd3, 1'b1, 0, 0);
    run_op(LW,  32'h0000_0301, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 0, 0);
    run_op(LW,  32'h0000_0400, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, -1, 1);
    run_op(5'b00010, 32'h0, 32'h0, 32'h0, 32'h0BAD_F00D, 5'd11, 1'b1, 0, 0);
    run_op(LH,  32'h0000_0502, 32'h0, 32'h9ABC_1234, 32'h0, 5'd12, 1'b1, 1, 2);
    run_op(SB,  32'h0000_0601, 32'h0000_00A5, 32'h0, 32'h0, 5'd1, 1'b1, 2, 1);

    // Randomized mix of memory and non-memory operations
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 10);
      if (r < 8)       op = 5'b10000 + 5'(r);
      else if (r == 8) op = 5'b11000 + 5'($urandom_range(0, 7));
      else             op = 5'($urandom_range(0, 15));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      dly = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 3);
      run_op(op, addr, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
             dly, $urandom_range(0, 2));
    end

    // Reset in the middle of a BUSY access
    mem_aluop    = LW;
    mem_mem_addr = 32'h0000_0700;
    mem_wreg     = 1'b1;
    stall        = 6'h0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", dm_req, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_req", dm_req, 0);
    check("async_rst_addr", dm_addr, 0);
    check("async_rst_be", dm_be, 0);
    dm_ack   = 1'b1;
    dm_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst          = 1'b1;
    mem_aluop    = 5'b00011;
    mem_wd       = 5'd21;
    mem_wreg     = 1'b1;
    mem_wdata    = 32'h1357_9BDF;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_req", dm_req, 0);
    check("post_rst_stall", stallreq_mem, 0);
    check("post_rst_wd", wb_wd, 5'd21);
    check("post_rst_wreg", wb_wreg, 1);
    check("post_rst_wdata", wb_wdata, 32'h1357_9BDF);
    dm_ack = 1'b0;
    @(posedge clk); #1;
    run_op(SW, 32'h0000_0800, 32'hCAFE_F00D, 32'h0, 32'h0, 5'd2, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs in the 5-stage RISC-V core.
- Decodes load/store aluop codes and performs the access on the data-memory req/ack bus, with byte lanes, alignment checks and load sign/zero extension.
- Raises a stall request to the pipeline controller while an access is outstanding.
- Delivers the write-back triple (wd, wreg, wdata) to the MEM/WB register.

Parameters:
- TIMEOUT, 16: max BUSY cycles waiting for dm_ack; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- stall  input  6  pipeline stall vector; bit 4 = MEM stage held.
- mem_aluop  input  5  operation code.
- mem_mem_addr  input  32  byte address.
- mem_reg2  input  32  store data.
- mem_wd  input  5  destination register.
- mem_wreg  input  1  write-register flag.
- mem_wdata  input  32  ALU result for non-memory ops.
- dm_req  output  1  bus request.
- dm_we  output  1  1 = store.
- dm_addr  output  32  word address: {addr[31:2], 2'b00}.
- dm_be  output  4  byte enables.
- dm_wdata  output  32  store data, lane-replicated.
- dm_rdata  input  32  read data; valid only with dm_ack.
- dm_ack  input  1  single-cycle completion.
- stallreq_mem  output  1  stall request to the controller.
- wb_wd  output  5  to MEM/WB.
- wb_wreg  output  1  to MEM/WB.
- wb_wdata  output  32  to MEM/WB.
- misalign  output  1  misaligned access flag, combinational.
- bus_err  output  1  one-cycle pulse on timeout.

Behaviour:
- Opcodes:
  - Loads: LB=10000, LH=10001, LW=10010, LBU=10011, LHU=10100.
  - Stores: SB=10101, SH=10110, SW=10111.
  - Any other code is a non-memory op.
- Misaligned access:
  - Halfword ops with addr[0]=1, or word ops with addr[1:0]!=0.
  - misalign=1; no bus cycle; wb_wreg=0; stallreq_mem=0.
- FSM state IDLE:
  - Non-memory op: wb_* = mem_wd / mem_wreg / mem_wdata combinationally; stallreq_mem=0.
  - Aligned memory op: stallreq_mem=1 combinationally; next state BUSY; dm_* registered from the inputs; timer cleared.
- FSM state BUSY:
  - dm_req=1, with addr/we/be/wdata held stable until dm_ack; stallreq_mem=1.
  - On dm_ack: capture the extended load value into rdata_q; dm_req=0 next cycle; go to DONE.
  - Timeout: if TIMEOUT!=0 and the timer reaches TIMEOUT-1 without ack, drop dm_req, pulse bus_err for 1 cycle, set err_q, go to DONE.
- FSM state DONE:
  - stallreq_mem=0.
  - Loads: wb_wreg=mem_wreg & ~err_q; wb_wdata=rdata_q.
  - Stores: wb_wreg=0.
  - If stall[4]=1, hold DONE; else go to IDLE next cycle and clear err_q.
- Memory op in IDLE or BUSY: wb_wreg=0; wb_wdata=0.
- Lanes, with byte offset k = addr[1:0]:
  - SB: be=1<<k; wdata={4{reg2[7:0]}}.
  - SH: be=0011 or 1100; wdata={2{reg2[15:0]}}.
  - SW: be=1111.
  - Loads: be=1111; byte/halfword selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- dm_ack outside BUSY is ignored.
- Reset (asserted at any time, including mid-BUSY):
  - Immediately: state=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_be=0, dm_wdata=0, rdata_q=0, err_q=0, timer=0, bus_err=0.
  - A pending ack after reset release is ignored.
- Latency: a load/store with ack on the first BUSY cycle stalls exactly 2 cycles (IDLE, BUSY), then presents its result in DONE.

Test Plan:
- Non-memory op: aluop=00001, wd=5, wreg=1, wdata=0xDEADBEEF -> same-cycle wb_wd=5, wb_wreg=1, wb_wdata=0xDEADBEEF; stallreq_mem=0; dm_req never 1.
- LB at addr 0x103, memory responds rdata=0x80AA55CC after 3 cycles:
  - dm_addr=0x100, dm_be=1111, stallreq_mem high for 5 cycles.
  - In DONE: wb_wdata=0xFFFFFF80.
  - Repeat with LBU -> 0x00000080.
- SH at 0x202 with reg2=0x1234ABCD, ack on the first BUSY cycle -> dm_we=1, dm_be=1100, dm_wdata=0xABCDABCD; 2 stall cycles; wb_wreg=0.
- LW at 0x301 -> misalign=1, dm_req=0, wb_wreg=0, stallreq_mem=0.
- TIMEOUT=4, LW with ack never asserted -> dm_req high exactly 4 cycles; bus_err pulses once; DONE gives wb_wreg=0; a late ack is ignored.
- Assert rst low mid-BUSY -> dm_req=0 without waiting for a clock edge; after release, state is IDLE and a non-memory op passes through correctly.
